// File: rtl/coinc_pkg.sv
// Shared types and default parameter values for the coincidence counter.
package coinc_pkg;

    localparam int NCHAN_DEF = 4;
    localparam int WBITS_DEF = 4;
    localparam int CBITS_DEF = 16;
    localparam int GBITS_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } coinc_state_e;

endpackage

// File: rtl/coinc_gate_timer.sv
// Gate timer: counts enabled cycles and pulses GateClose on the GatePeriod-th one.
// GatePeriod of 0 wraps the compare and so yields a gate of 2^GBITS cycles.
module coinc_gate_timer
    import coinc_pkg::*;
#(
    parameter int GBITS = GBITS_DEF
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Enable,
    input  logic [GBITS-1:0] GatePeriod,
    output logic             GateClose
);

    logic [GBITS-1:0] cnt_q;
    logic [GBITS-1:0] cnt_d;

    // next count and close pulse
    always_comb begin
        cnt_d     = cnt_q;
        GateClose = 1'b0;
        if (Enable) begin
            if (cnt_q == (GatePeriod - GBITS'(1))) begin
                GateClose = 1'b1;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_q + GBITS'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/coincidence_counter.sv
// Windowed coincidence detector with gated, saturating counter and ready/valid output.
// Optional per-channel singles counters are enabled with the COINC_SINGLES_EN macro.
module coincidence_counter
    import coinc_pkg::*;
#(
    parameter int NCHAN = NCHAN_DEF,
    parameter int WBITS = WBITS_DEF,
    parameter int CBITS = CBITS_DEF,
    parameter int GBITS = GBITS_DEF
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [NCHAN-1:0] DlayChann,
    input  logic [NCHAN-1:0] Mask,
    input  logic [WBITS-1:0] Window,
    input  logic [GBITS-1:0] GatePeriod,
    input  logic             Enable,
    output logic [CBITS-1:0] CntData,
    output logic             CntValid,
    input  logic             CntReady,
    output logic             Overrun
`ifdef COINC_SINGLES_EN
    ,
    output logic [NCHAN-1:0][CBITS-1:0] Singles
`endif
);

    function automatic logic [CBITS-1:0] sat_inc(input logic [CBITS-1:0] v, input logic inc);
        if (inc && (v != {CBITS{1'b1}})) begin
            return v + CBITS'(1);
        end else begin
            return v;
        end
    endfunction

    logic [NCHAN-1:0] prev_q, prev_d;
    logic [NCHAN-1:0] hits_q, hits_d;
    logic [WBITS-1:0] win_q, win_d;
    coinc_state_e     state_q, state_d;
    logic [CBITS-1:0] acc_q, acc_d;
    logic [CBITS-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic [NCHAN-1:0] rise_s;
    logic [NCHAN-1:0] merged_s;
    logic             coinc_s;
    logic             gate_close_s;
    logic [CBITS-1:0] result_s;
    logic             take_s;

    coinc_gate_timer #(
        .GBITS(GBITS)
    ) u_gate_timer (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Enable    (Enable),
        .GatePeriod(GatePeriod),
        .GateClose (gate_close_s)
    );

    assign rise_s   = DlayChann & ~prev_q & Mask;
    assign merged_s = hits_q | rise_s;
    assign prev_d   = DlayChann;

    // window FSM: a coincidence is the first cycle all masked channels have risen
    always_comb begin
        state_d = state_q;
        hits_d  = hits_q;
        win_d   = win_q;
        coinc_s = 1'b0;
        if (!Enable) begin
            state_d = IDLE;
            hits_d  = '0;
            win_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise_s != '0) begin
                        hits_d = rise_s;
                        win_d  = Window;
                        if (rise_s == Mask) begin
                            coinc_s = 1'b1;
                        end else if (Window != '0) begin
                            state_d = OPEN;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                OPEN: begin
                    hits_d = merged_s;
                    win_d  = win_q - WBITS'(1);
                    if (merged_s == Mask) begin
                        coinc_s = 1'b1;
                        hits_d  = '0;
                        state_d = IDLE;
                    end else if (win_q <= WBITS'(1)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = OPEN;
                    end
                end
                default: begin
                    state_d = IDLE;
                    hits_d  = '0;
                    win_d   = '0;
                end
            endcase
        end
    end

    assign result_s = sat_inc(acc_q, coinc_s);
    // a closing gate's result is accepted only if the output slot is free or being read
    assign take_s   = !valid_q || CntReady;

    // accumulator and output handshake
    always_comb begin
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (gate_close_s) begin
            acc_d = '0;
            if (take_s) begin
                data_d  = result_s;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else begin
            acc_d = result_s;
            if (valid_q && CntReady) begin
                valid_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
        end
    end

    // state registers
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            prev_q  <= '0;
            hits_q  <= '0;
            win_q   <= '0;
            state_q <= IDLE;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            hits_q  <= hits_d;
            win_q   <= win_d;
            state_q <= state_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign CntData  = data_q;
    assign CntValid = valid_q;
    assign Overrun  = ovr_q;

`ifdef COINC_SINGLES_EN
    logic [NCHAN-1:0][CBITS-1:0] sgl_acc_q, sgl_acc_d;
    logic [NCHAN-1:0][CBITS-1:0] sgl_data_q, sgl_data_d;
    logic [NCHAN-1:0][CBITS-1:0] sgl_res_s;

    // per-channel singles follow the same gate and handshake rules as CntData
    always_comb begin
        sgl_acc_d  = sgl_acc_q;
        sgl_data_d = sgl_data_q;
        sgl_res_s  = sgl_acc_q;
        for (int i = 0; i < NCHAN; i++) begin
            sgl_res_s[i] = sat_inc(sgl_acc_q[i], rise_s[i] & Enable);
            if (gate_close_s) begin
                sgl_acc_d[i] = '0;
                if (take_s) begin
                    sgl_data_d[i] = sgl_res_s[i];
                end else begin
                    sgl_data_d[i] = sgl_data_q[i];
                end
            end else begin
                sgl_acc_d[i] = sgl_res_s[i];
            end
        end
    end

    // singles registers
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            sgl_acc_q  <= '0;
            sgl_data_q <= '0;
        end else begin
            sgl_acc_q  <= sgl_acc_d;
            sgl_data_q <= sgl_data_d;
        end
    end

    assign Singles = sgl_data_q;
`endif

endmodule

// File: tb/tb_coincidence_counter.sv
// Directed testbench for coincidence_counter (default build, plus a CBITS=4 instance).
module tb_coincidence_counter;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [3:0]  DlayChann;
    logic [3:0]  Mask;
    logic [3:0]  Window;
    logic [15:0] GatePeriod;
    logic        Enable;
    logic        CntReady;
    logic [15:0] cnt_data;
    logic        cnt_valid;
    logic        overrun;
    logic [3:0]  sat_data;
    logic        sat_valid;
    logic        sat_ovr;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    coincidence_counter dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .DlayChann (DlayChann),
        .Mask      (Mask),
        .Window    (Window),
        .GatePeriod(GatePeriod),
        .Enable    (Enable),
        .CntData   (cnt_data),
        .CntValid  (cnt_valid),
        .CntReady  (CntReady),
        .Overrun   (overrun)
    );

    coincidence_counter #(.CBITS(4)) dut_sat (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .DlayChann (DlayChann),
        .Mask      (Mask),
        .Window    (Window),
        .GatePeriod(GatePeriod),
        .Enable    (Enable),
        .CntData   (sat_data),
        .CntValid  (sat_valid),
        .CntReady  (CntReady),
        .Overrun   (sat_ovr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] v);
        DlayChann = v;
        tick();
        DlayChann = 4'b0000;
        tick();
    endtask

    task automatic do_reset();
        Rst_n     = 1'b0;
        Enable    = 1'b0;
        DlayChann = 4'b0000;
        tick();
        tick();
        Rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int bound);
        int n;
        n = 0;
        while (!cnt_valid && n < bound) begin
            tick();
            n++;
        end
        check_eq("valid_seen", {31'd0, cnt_valid}, 32'd1);
    endtask

    initial begin
        int n;
        Rst_n      = 1'b0;
        DlayChann  = 4'b0000;
        Mask       = 4'b0011;
        Window     = 4'd2;
        GatePeriod = 16'd40;
        Enable     = 1'b0;
        CntReady   = 1'b1;

        // reset state
        do_reset();
        check_eq("rst_data", {16'd0, cnt_data}, 32'd0);
        check_eq("rst_valid", {31'd0, cnt_valid}, 32'd0);
        check_eq("rst_ovr", {31'd0, overrun}, 32'd0);

        // window of 3 cycles: ch1 at t+2 counts, at t+3 does not
        Enable = 1'b1;
        DlayChann = 4'b0001; tick(); tick();
        DlayChann = 4'b0011; tick();
        DlayChann = 4'b0000; tick();
        DlayChann = 4'b0001; tick(); tick(); tick();
        DlayChann = 4'b0011; tick();
        DlayChann = 4'b0000; tick();
        wait_valid(60);
        check_eq("win2_count", {16'd0, cnt_data}, 32'd1);
        check_eq("win2_count_sat", {28'd0, sat_data}, 32'd1);

        // Window=0: five simultaneous pairs count, a staggered pair and unmasked ch1 do not
        Mask = 4'b0101; Window = 4'd0; GatePeriod = 16'd40;
        do_reset();
        Enable = 1'b1;
        for (int i = 0; i < 5; i++) pulse(4'b0101);
        DlayChann = 4'b0001; tick();
        DlayChann = 4'b0101; tick();
        DlayChann = 4'b0000; tick();
        pulse(4'b0010);
        wait_valid(60);
        check_eq("simul_5", {16'd0, cnt_data}, 32'd5);

        // Mask==0 never counts
        Mask = 4'b0000; Window = 4'd2; GatePeriod = 16'd8;
        do_reset();
        Enable = 1'b1;
        pulse(4'b1111);
        pulse(4'b1111);
        wait_valid(10);
        check_eq("mask0", {16'd0, cnt_data}, 32'd0);

        // gate spacing of 8, stretched by 3 disabled cycles
        wait_valid(10);
        n = 0;
        do begin tick(); n++; end while (!cnt_valid && n < 30);
        check_eq("gate_period", n, 32'd8);
        Enable = 1'b0;
        tick(); tick(); tick();
        Enable = 1'b1;
        n = 3;
        do begin tick(); n++; end while (!cnt_valid && n < 30);
        check_eq("gate_hold", n, 32'd11);

        // overrun: consumer stalled across two gate closes
        Mask = 4'b0011; Window = 4'd0; GatePeriod = 16'd8; CntReady = 1'b0;
        do_reset();
        Enable = 1'b1;
        pulse(4'b0011);
        pulse(4'b0011);
        wait_valid(10);
        check_eq("ovr_first", {16'd0, cnt_data}, 32'd2);
        pulse(4'b0011);
        repeat (8) tick();
        check_eq("ovr_flag", {31'd0, overrun}, 32'd1);
        check_eq("ovr_keep", {16'd0, cnt_data}, 32'd2);
        check_eq("ovr_valid", {31'd0, cnt_valid}, 32'd1);
        CntReady = 1'b1;
        tick();
        CntReady = 1'b0;
        check_eq("ovr_drain", {31'd0, cnt_valid}, 32'd0);
        check_eq("ovr_sticky", {31'd0, overrun}, 32'd1);

        // saturation: 20 coincidences, CBITS=4 clamps at 15
        Mask = 4'b0001; Window = 4'd0; GatePeriod = 16'd50; CntReady = 1'b1;
        do_reset();
        Enable = 1'b1;
        for (int i = 0; i < 20; i++) pulse(4'b0001);
        wait_valid(30);
        check_eq("sat_wide", {16'd0, cnt_data}, 32'd20);
        check_eq("sat_narrow", {28'd0, sat_data}, 32'd15);
        check_eq("sat_no_ovr", {31'd0, sat_ovr}, 32'd0);

        // reset while OPEN with a partial count, then a fresh gate
        Mask = 4'b0011; Window = 4'd3; GatePeriod = 16'd10; CntReady = 1'b0;
        do_reset();
        Enable = 1'b1;
        for (int i = 0; i < 3; i++) pulse(4'b0011);
        wait_valid(10);
        check_eq("pre_rst_data", {16'd0, cnt_data}, 32'd3);
        repeat (10) tick();
        check_eq("pre_rst_ovr", {31'd0, overrun}, 32'd1);
        for (int i = 0; i < 3; i++) pulse(4'b0011);
        DlayChann = 4'b0001; tick();
        Rst_n = 1'b0; tick();
        check_eq("mid_rst_data", {16'd0, cnt_data}, 32'd0);
        check_eq("mid_rst_valid", {31'd0, cnt_valid}, 32'd0);
        check_eq("mid_rst_ovr", {31'd0, overrun}, 32'd0);
        Rst_n = 1'b1; CntReady = 1'b1;
        tick();
        DlayChann = 4'b0011; tick();
        DlayChann = 4'b0000;
        wait_valid(15);
        check_eq("post_rst_count", {16'd0, cnt_data}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/coincidence_counter.md
COINCIDENCE_COUNTER -- requirements
Module: coincidence_counter

Interface
REQ-001 The block SHALL have parameter NCHAN, default 4, meaning the number of delayed input channels.
REQ-002 The block SHALL have parameter WBITS, default 4, meaning the width of the coincidence-window setting.
REQ-003 The block SHALL have parameter CBITS, default 16, meaning the width of the counters.
REQ-004 The block SHALL have parameter GBITS, default 16, meaning the width of the gate-period setting.
REQ-005 Clk  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-006 Rst_n  input  1  reset, synchronous and active-low.
REQ-007 DlayChann  input  NCHAN  delayed channel levels from the delay stage.
REQ-008 Mask  input  NCHAN  channels that must all fire for a coincidence.
REQ-009 Window  input  WBITS  extra cycles the window stays open after the first hit.
REQ-010 GatePeriod  input  GBITS  gate length in enabled cycles; 0 means 2^GBITS.
REQ-011 Enable  input  1  run/hold control.
REQ-012 CntData  output  CBITS  coincidence count of the last completed gate.
REQ-013 CntValid  output  1  CntData holds unread data.
REQ-014 CntReady  input  1  consumer accepts CntData.
REQ-015 Overrun  output  1  sticky flag: a gate result was dropped.

Function
REQ-016 Rise SHALL be DlayChann & ~prev & Mask, where prev is DlayChann registered on the previous cycle.
REQ-017 The FSM SHALL have two states: IDLE and OPEN.
REQ-018 In IDLE with Rise != 0, the block SHALL load Hits=Rise and WinCnt=Window; the next state SHALL be OPEN unless the coincidence condition already holds.
REQ-019 In OPEN, Hits SHALL accumulate Hits|Rise each cycle and WinCnt SHALL decrement.
REQ-020 OPEN SHALL return to IDLE without a count when WinCnt is 0 and (Hits|Rise) != Mask.
REQ-021 A coincidence SHALL be declared in the cycle where (Hits|Rise)==Mask; the FSM SHALL then go to IDLE, and all other edges in that cycle SHALL be discarded.
REQ-022 The total window SHALL be Window+1 cycles; Window=0 SHALL count only fully simultaneous edges.
REQ-023 With Mask==0 the FSM SHALL never leave IDLE and no coincidence SHALL be counted.
REQ-024 On each coincidence the accumulator SHALL increment by 1 at the next clock edge, saturating at 2^CBITS-1.
REQ-025 The gate timer SHALL count the cycles in which Enable=1; a gate SHALL close on its GatePeriod-th enabled cycle.
REQ-026 At gate close, the accumulator plus any same-cycle coincidence SHALL transfer to CntData, CntValid SHALL set, and the accumulator SHALL clear to 0.
REQ-027 A handshake SHALL complete when CntValid=1 and CntReady=1; CntValid SHALL then clear, unless a gate closes in the same cycle, in which case the new data SHALL load and CntValid SHALL stay 1.
REQ-028 When a gate closes while CntValid=1 and CntReady=0, CntData SHALL be kept, the new result SHALL be dropped, the accumulator SHALL still clear, and Overrun SHALL set.
REQ-029 While Enable=0 the FSM SHALL be forced to IDLE, and the gate timer and accumulator SHALL hold; the output handshake SHALL still operate.

Reset
REQ-030 While Rst_n=0 at a clock edge, all of the following SHALL be cleared to 0: prev, Hits, WinCnt, FSM (to IDLE), gate timer, accumulator, CntData, CntValid, Overrun.
REQ-031 Reset mid-window or mid-gate SHALL discard partial results.
REQ-032 A channel that is high at reset release SHALL register as a rising edge.

Configuration
REQ-033 With COINC_SINGLES_EN defined, the block SHALL add output Singles (NCHAN x CBITS).
REQ-034 Singles SHALL be per-channel saturating counts of Rise events (mask applied), latched at gate close under the same rules as CntData and sharing CntValid.
REQ-035 Without COINC_SINGLES_EN the Singles port and its counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-036 Package coinc_pkg SHALL hold the FSM state enum (IDLE, OPEN) and the default parameter constants.
REQ-037 The gate timer SHALL be sub-module coinc_gate_timer, which outputs a one-cycle GateClose pulse.

Verification
REQ-038 Mask=4'b0011, Window=2, ch0 rises at t, ch1 rises at t+2 -> one count; ch1 at t+3 -> no count.
REQ-039 Mask=4'b0101, Window=0, ch0 and ch2 rise in the same cycle, 5 times -> CntData=5 after the gate closes.
REQ-040 GatePeriod=8, Enable=1, CntReady=1 -> CntValid pulses every 8 cycles; Enable=0 for 3 cycles -> the next pulse comes 3 cycles late.
REQ-041 CntReady=0 across two gate closes -> CntData keeps the first result, Overrun=1; after CntReady=1 for one cycle -> CntValid=0.
REQ-042 CBITS=4 with 20 coincidences in one gate -> CntData=15.
REQ-043 Rst_n=0 for 1 cycle while OPEN with accumulator=3 -> all outputs 0 on the next cycle, and the next gate counts from 0.
